load_store_unit: RTL and testbench

//  Initiator side of the byte-enabled data-memory interface: converts CPU load/store requests
//  (RV32 funct3 encoding) into aligned word accesses (address, write data, byte enables, store_enable).

---
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns RV32 load/store requests into aligned, byte-enabled word accesses,
// splitting word-crossing accesses in two and aligning/extending the returned load data.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_enable,
  output logic        store_enable,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND, RESP} state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, lo_q, hi_q;

  logic [7:0]  mask;
  logic [5:0]  sh_lo, sh_hi;
  logic [31:0] word_addr, aligned_rd;
  logic        req_fire, req_reject;

  function automatic logic [2:0] size_of(input logic [1:0] sz_code);
    case (sz_code)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
    return (f3[1:0] == 2'b11) || (f3[2:1] == 2'b11) || (wr && f3[2]);
  endfunction

  function automatic logic crosses(input logic [1:0] sz_code, input logic [1:0] off);
    return ({1'b0, off} + size_of(sz_code)) > 3'd4;
  endfunction

  // Bits [3:0] are lanes of the first word, bits [7:4] lanes of the following word.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz_code, input logic [1:0] off);
    logic [7:0] m;
    case (sz_code)
      2'b00:   m = 8'h01;
      2'b01:   m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << off;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      3'b010:  return v;
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return 32'h0;
    endcase
  endfunction

  assign mask       = lane_mask(funct3_q[1:0], addr_q[1:0]);
  assign sh_lo      = {1'b0, addr_q[1:0], 3'b000};
  assign sh_hi      = 6'd32 - sh_lo;
  assign word_addr  = {addr_q[31:2], 2'b00};
  assign aligned_rd = 32'({hi_q, lo_q} >> sh_lo);
  assign req_fire   = req_valid && ready_q && (state_q == IDLE);
  assign req_reject = is_illegal(req_write, req_funct3) ||
                      (!ALLOW_MISALIGNED && crosses(req_funct3[1:0], req_addr[1:0]));

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (req_fire) begin
          ready_d = 1'b0;
          err_d   = req_reject;
          state_d = req_reject ? RESP : FIRST;
        end
      end
      FIRST:   state_d = (mask[7:4] != 4'h0) ? SECOND : RESP;
      SECOND:  state_d = RESP;
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Request latch and read buffers carry no reset: they are only consumed after being loaded.
  always_ff @(posedge clock) begin
    if (req_fire) begin
      write_q  <= req_write;
      funct3_q <= req_funct3;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end
    if (state_q == FIRST)  lo_q <= mem_read_data;
    if (state_q == SECOND) hi_q <= mem_read_data;
  end

  always_comb begin
    req_ready        = ready_q;
    resp_valid       = 1'b0;
    resp_error       = 1'b0;
    resp_rdata       = 32'h0;
    mem_address      = 32'h0;
    mem_write_data   = 32'h0;
    mem_write_enable = 4'h0;
    store_enable     = 1'b0;
    case (state_q)
      FIRST: begin
        mem_address      = word_addr;
        mem_write_data   = wdata_q << sh_lo;
        mem_write_enable = write_q ? mask[3:0] : 4'h0;
        store_enable     = write_q;
      end
      SECOND: begin
        mem_address      = word_addr + 32'd4;
        mem_write_data   = wdata_q >> sh_hi;
        mem_write_enable = write_q ? mask[7:4] : 4'h0;
        store_enable     = write_q;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_error = err_q;
        resp_rdata = (err_q || write_q) ? 32'h0 : extend(funct3_q, aligned_rd);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory plus a byte-level reference model,
// directed scenarios and randomized load/store traffic on both misalignment configurations.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid0 = 1'b0, req_valid1 = 1'b0, req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

  logic        ready0, rvalid0, err0, se0, ready1, rvalid1, err1, se1;
  logic [31:0] rdata0, maddr0, mwdata0, mrd0, rdata1, maddr1, mwdata1;
  logic [31:0] mrd1 = 32'hCAFEF00D;
  logic [3:0]  men0, men1;

  logic        sel = 1'b0;
  logic        s_ready, s_rvalid, s_err, s_se;
  logic [31:0] s_rdata, s_maddr, s_mwdata;
  logic [3:0]  s_men;

  int checks = 0, failures = 0;

  logic [7:0]  mem     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic        mem_load = 1'b0;

  logic [31:0] cap_addr[$], cap_data[$];
  logic [3:0]  cap_en[$];

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut0 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(ready0),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid0), .resp_rdata(rdata0), .resp_error(err0), .mem_address(maddr0),
    .mem_write_data(mwdata0), .mem_write_enable(men0), .store_enable(se0), .mem_read_data(mrd0));

  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut1 (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(ready1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid1), .resp_rdata(rdata1), .resp_error(err1), .mem_address(maddr1),
    .mem_write_data(mwdata1), .mem_write_enable(men1), .store_enable(se1), .mem_read_data(mrd1));

  always #5 clock = ~clock;

  assign s_ready  = sel ? ready1  : ready0;
  assign s_rvalid = sel ? rvalid1 : rvalid0;
  assign s_err    = sel ? err1    : err0;
  assign s_se     = sel ? se1     : se0;
  assign s_rdata  = sel ? rdata1  : rdata0;
  assign s_maddr  = sel ? maddr1  : maddr0;
  assign s_mwdata = sel ? mwdata1 : mwdata0;
  assign s_men    = sel ? men1    : men0;

  always_comb begin
    mrd0 = {mem[{maddr0[9:2], 2'd3}], mem[{maddr0[9:2], 2'd2}],
            mem[{maddr0[9:2], 2'd1}], mem[{maddr0[9:2], 2'd0}]};
  end

  always @(posedge clock) begin
    if (mem_load) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else if (se0) begin
      for (int i = 0; i < 4; i++)
        if (men0[i]) mem[{maddr0[9:2], 2'(i)}] <= mwdata0[8*i +: 8];
    end
  end

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic illegal(input logic wr, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (wr && f3 >= 3'b100);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] v = 32'h0;
    int n = size_of(f3);
    for (int i = 0; i < n; i++) v |= 32'(ref_mem[10'(a + 32'(i))]) << (8 * i);
    if (!f3[2] && n == 1 && v[7])  v |= 32'hFFFFFF00;
    if (!f3[2] && n == 2 && v[15]) v |= 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++) ref_mem[10'(a + 32'(i))] = wd[8*i +: 8];
  endtask

  // Issues one request on the selected unit; lat counts cycles from the presenting cycle to resp_valid.
  task automatic do_req(input logic s, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int guard = 0;
    sel = s;
    cap_addr.delete(); cap_data.delete(); cap_en.delete();
    rd = 32'h0; er = 1'b0; lat = -1;
    while (!s_ready && guard < 50) begin @(posedge clock); #1; guard++; end
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout got=%b required=1", s_ready);
      return;
    end
    req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (s) req_valid1 = 1'b1; else req_valid0 = 1'b1;
    @(posedge clock); #1;
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (s_se) begin cap_addr.push_back(s_maddr); cap_en.push_back(s_men); cap_data.push_back(s_mwdata); end
      if (s_rvalid) begin rd = s_rdata; er = s_err; lat = c; break; end
      @(posedge clock); #1;
    end
    if (lat < 0) begin
      checks++; failures++;
      $display("FAIL resp_timeout no resp_valid within 10 cycles");
    end
  endtask

  task automatic test_reset();
    logic [107:0] got;
    mem_load = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    mem_load = 1'b0;
    got = {ready0, rvalid0, err0, se0, men0, maddr0, rdata0, mwdata0};
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_outputs got=%h required=0", got); end
    got = {ready1, rvalid1, err1, se1, men1, maddr1, rdata1, mwdata1};
    checks++;
    if (got !== '0) begin failures++; $display("FAIL reset_outputs_u1 got=%h required=0", got); end
    #3 reset_n = 1'b1;
    #1;
    checks++;
    if (ready0 !== 1'b0) begin failures++; $display("FAIL ready_before_edge got=%b required=0", ready0); end
    @(posedge clock); #1;
    checks++;
    if ({ready0, ready1} !== 2'b11) begin failures++; $display("FAIL ready_after_release got=%b required=11", {ready0, ready1}); end
  endtask

  task automatic test_sw_aligned();
    logic [31:0] rd; logic er; int lat;
    logic [67:0] got;
    do_req(1'b0, 1'b1, 3'b010, 32'h08, 32'hDEADBEEF, rd, er, lat);
    ref_store(32'h08, 3'b010, 32'hDEADBEEF);
    got = (cap_en.size() == 1) ? {cap_addr[0], cap_en[0], cap_data[0]} : '0;
    checks++;
    if (got !== {32'h08, 4'b1111, 32'hDEADBEEF}) begin failures++; $display("FAIL sw_access got=%h required=%h", got, {32'h08, 4'b1111, 32'hDEADBEEF}); end
    checks++;
    if ({er, lat} !== {1'b0, 32'd2}) begin failures++; $display("FAIL sw_resp err=%b lat=%0d required err=0 lat=2", er, lat); end
    do_req(1'b0, 1'b0, 3'b010, 32'h08, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_after_sw got=%h required=deadbeef", rd); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    logic [67:0] got;
    do_req(1'b0, 1'b1, 3'b000, 32'h0D, 32'h000000A5, rd, er, lat);
    ref_store(32'h0D, 3'b000, 32'h000000A5);
    got = (cap_en.size() == 1) ? {cap_addr[0], cap_en[0], cap_data[0]} : '0;
    checks++;
    if (got !== {32'h0C, 4'b0010, 32'h0000A500}) begin failures++; $display("FAIL sb_access got=%h required=%h", got, {32'h0C, 4'b0010, 32'h0000A500}); end
    do_req(1'b0, 1'b0, 3'b000, 32'h0D, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_sign got=%h required=ffffffa5", rd); end
    do_req(1'b0, 1'b0, 3'b100, 32'h0D, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h000000A5) begin failures++; $display("FAIL lbu_zero got=%h required=000000a5", rd); end
  endtask

  task automatic test_split_store();
    logic [31:0] rd; logic er; int lat;
    logic [135:0] got, exp;
    do_req(1'b0, 1'b1, 3'b010, 32'h0E, 32'h11223344, rd, er, lat);
    ref_store(32'h0E, 3'b010, 32'h11223344);
    exp = {32'h0C, 4'b1100, 32'h33440000, 32'h10, 4'b0011, 32'h00001122};
    got = (cap_en.size() == 2) ? {cap_addr[0], cap_en[0], cap_data[0], cap_addr[1], cap_en[1], cap_data[1]} : '0;
    checks++;
    if (got !== exp) begin failures++; $display("FAIL split_sw_access got=%h required=%h", got, exp); end
    do_req(1'b0, 1'b0, 3'b010, 32'h0E, 32'h0, rd, er, lat);
    checks++;
    if ({rd, lat} !== {32'h11223344, 32'd3}) begin failures++; $display("FAIL split_lw got=%h lat=%0d required=11223344 lat=3", rd, lat); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b1, 3'b000, 32'h03, 32'h80, rd, er, lat);
    ref_store(32'h03, 3'b000, 32'h80);
    do_req(1'b0, 1'b1, 3'b000, 32'h04, 32'h7F, rd, er, lat);
    ref_store(32'h04, 3'b000, 32'h7F);
    do_req(1'b0, 1'b0, 3'b001, 32'h03, 32'h0, rd, er, lat);
    checks++;
    if ({rd, lat} !== {32'h00007F80, 32'd3}) begin failures++; $display("FAIL split_lh got=%h lat=%0d required=00007f80 lat=3", rd, lat); end
    do_req(1'b0, 1'b1, 3'b001, 32'h02, 32'h8001, rd, er, lat);
    ref_store(32'h02, 3'b001, 32'h8001);
    do_req(1'b0, 1'b0, 3'b001, 32'h02, 32'h0, rd, er, lat);
    checks++;
    if ({rd, lat} !== {32'hFFFF8001, 32'd2}) begin failures++; $display("FAIL lh_sign got=%h lat=%0d required=ffff8001 lat=2", rd, lat); end
    do_req(1'b0, 1'b0, 3'b101, 32'h02, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00008001) begin failures++; $display("FAIL lhu_zero got=%h required=00008001", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    do_req(1'b0, 1'b0, 3'b011, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if ({rd, er, lat, cap_en.size()} !== {32'h0, 1'b1, 32'd1, 32'd0}) begin failures++; $display("FAIL illegal_011 rd=%h err=%b lat=%0d", rd, er, lat); end
    do_req(1'b0, 1'b1, 3'b100, 32'h20, 32'h55, rd, er, lat);
    checks++;
    if ({rd, er, cap_en.size()} !== {32'h0, 1'b1, 32'd0}) begin failures++; $display("FAIL illegal_store_bu rd=%h err=%b writes=%0d", rd, er, cap_en.size()); end
    do_req(1'b1, 1'b0, 3'b010, 32'h01, 32'h0, rd, er, lat);
    checks++;
    if ({rd, er, lat} !== {32'h0, 1'b1, 32'd1}) begin failures++; $display("FAIL strict_lw_misaligned rd=%h err=%b lat=%0d", rd, er, lat); end
    do_req(1'b1, 1'b1, 3'b010, 32'h03, 32'h12345678, rd, er, lat);
    checks++;
    if ({er, cap_en.size()} !== {1'b1, 32'd0}) begin failures++; $display("FAIL strict_sw_misaligned err=%b writes=%0d", er, cap_en.size()); end
    do_req(1'b1, 1'b0, 3'b001, 32'h02, 32'h0, rd, er, lat);
    checks++;
    if ({rd, er, lat} !== {32'hFFFFCAFE, 1'b0, 32'd2}) begin failures++; $display("FAIL strict_lh_inword rd=%h err=%b lat=%0d required ffffcafe 0 2", rd, er, lat); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic er; int lat;
    logic [71:0] got;
    do_req(1'b0, 1'b1, 3'b010, 32'hFFFFFFFF, 32'hA1B2C3D4, rd, er, lat);
    ref_store(32'hFFFFFFFF, 3'b010, 32'hA1B2C3D4);
    got = (cap_en.size() == 2) ? {cap_addr[0], cap_en[0], cap_addr[1], cap_en[1]} : '0;
    checks++;
    if (got !== {32'hFFFFFFFC, 4'b1000, 32'h0, 4'b0111}) begin failures++; $display("FAIL wrap_access got=%h", got); end
    do_req(1'b0, 1'b0, 3'b010, 32'hFFFFFFFF, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA1B2C3D4) begin failures++; $display("FAIL wrap_lw got=%h required=a1b2c3d4", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp = ref_load(32'h20, 3'b010);
    int pulses = 0, bad = 0, guard = 0;
    sel = 1'b0;
    while (!ready0 && guard < 50) begin @(posedge clock); #1; guard++; end
    req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0;
    req_valid0 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clock); #1;
      if (rvalid0) begin pulses++; if (rdata0 !== exp) bad++; end
    end
    req_valid0 = 1'b0;
    checks++;
    if ({pulses, bad} !== {32'd3, 32'd0}) begin failures++; $display("FAIL back_to_back pulses=%0d bad=%0d required 3 0", pulses, bad); end
  endtask

  task automatic test_reset_split();
    logic [31:0] rd; logic er; int lat;
    logic [7:0] b44, b45;
    logic [107:0] got;
    int guard = 0;
    b44 = ref_mem[10'h44]; b45 = ref_mem[10'h45];
    sel = 1'b0;
    while (!ready0 && guard < 50) begin @(posedge clock); #1; guard++; end
    req_write = 1'b1; req_funct3 = 3'b010; req_addr = 32'h42; req_wdata = 32'hCAFEBABE;
    req_valid0 = 1'b1;
    @(posedge clock); #1;
    req_valid0 = 1'b0;
    @(posedge clock); #1;
    checks++;
    if ({se0, men0, maddr0} !== {1'b1, 4'b0011, 32'h44}) begin failures++; $display("FAIL second_half got=%b %b %h", se0, men0, maddr0); end
    #2 reset_n = 1'b0;
    #1;
    got = {ready0, rvalid0, err0, se0, men0, maddr0, rdata0, mwdata0};
    checks++;
    if (got !== '0) begin failures++; $display("FAIL async_reset_outputs got=%h required=0", got); end
    @(posedge clock); #1;
    checks++;
    if ({mem[10'h42], mem[10'h43], mem[10'h44], mem[10'h45]} !== {8'hBE, 8'hBA, b44, b45}) begin
      failures++; $display("FAIL split_abandon got=%h required=%h", {mem[10'h42], mem[10'h43], mem[10'h44], mem[10'h45]}, {8'hBE, 8'hBA, b44, b45});
    end
    ref_store(32'h42, 3'b001, 32'h0000BABE);
    #3 reset_n = 1'b1;
    #1;
    checks++;
    if (ready0 !== 1'b0) begin failures++; $display("FAIL ready_in_release_cycle got=%b required=0", ready0); end
    @(posedge clock); #1;
    checks++;
    if (ready0 !== 1'b1) begin failures++; $display("FAIL ready_after_release2 got=%b required=1", ready0); end
    do_req(1'b0, 1'b0, 3'b010, 32'h44, 32'h0, rd, er, lat);
    checks++;
    if (rd !== ref_load(32'h44, 3'b010)) begin failures++; $display("FAIL lw_after_abandon got=%h required=%h", rd, ref_load(32'h44, 3'b010)); end
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd; logic er, wr, exp_er; logic [2:0] f3; int lat, exp_lat;
    for (int n = 0; n < 60; n++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      wd = $urandom;
      exp_er  = illegal(wr, f3);
      exp_lat = exp_er ? 1 : ((a % 4) + size_of(f3) > 4) ? 3 : 2;
      exp_rd  = (exp_er || wr) ? 32'h0 : ref_load(a, f3);
      do_req(1'b0, wr, f3, a, wd, rd, er, lat);
      if (wr && !exp_er) ref_store(a, f3, wd);
      checks++;
      if ({rd, er, lat} !== {exp_rd, exp_er, exp_lat}) begin
        failures++;
        $display("FAIL random wr=%b f3=%b a=%h got rd=%h err=%b lat=%0d required rd=%h err=%b lat=%0d",
                 wr, f3, a, rd, er, lat, exp_rd, exp_er, exp_lat);
      end
    end
  endtask

  task automatic test_memory_image();
    int diffs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) diffs++;
    checks++;
    if (diffs != 0) begin failures++; $display("FAIL memory_image differing_bytes=%0d required=0", diffs); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    test_reset();
    test_sw_aligned();
    test_byte();
    test_split_store();
    test_half();
    test_errors();
    test_wrap();
    test_back_to_back();
    test_reset_split();
    test_random();
    test_memory_image();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
